i2c_master_byte: RTL and testbench

Byte-level I2C bus initiator that executes START, WRITE-byte, READ-byte and STOP commands issued over a valid/ready command port. It generates SCL and SDA as open-drain drive-low enables, so a board-level or bench pull-up completes the bus. It supports SCL clock stretching by the target. It sits under the i2c_axi_lite register front-end and is the counterpart to the I2C EEPROM target used on the bench.

---
 rtl/i2c_master_byte_if.sv | 27 ++
 rtl/i2c_master_byte.sv | 173 +++++++++++++++++
 tb/tb_i2c_master_byte.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_byte_if.sv
// Command/response handshake and open-drain I2C pins of the byte-level I2C master.
// The master modport is the controller side; the slave modport is the command issuer and bus side.
interface i2c_master_byte_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_code;
  logic [7:0] cmd_wdata;
  logic       cmd_mack;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  logic       scl_oe;
  logic       scl_i;
  logic       sda_oe;
  logic       sda_i;

  modport master (
    input  cmd_valid, cmd_code, cmd_wdata, cmd_mack, scl_i, sda_i,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_nack, busy, scl_oe, sda_oe
  );

  modport slave (
    output cmd_valid, cmd_code, cmd_wdata, cmd_mack, scl_i, sda_i,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack, busy, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: START / WRITE / READ / STOP commands, open-drain drive enables,
// quarter-period sequencing with SCL stretching by the target.
module i2c_master_byte #(
  parameter int DIVIDER = 16
) (
  input  logic clk,
  input  logic rst,
  i2c_master_byte_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_RESP} state_t;

  localparam logic [1:0]  CMD_START = 2'd0;
  localparam logic [1:0]  CMD_READ  = 2'd2;
  localparam logic [1:0]  CMD_STOP  = 2'd3;
  localparam logic [15:0] CNT_LAST  = 16'(DIVIDER - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  ph;
  logic [3:0]  bit_idx;
  logic        is_read;
  logic        mack;
  logic [7:0]  tx;
  logic [7:0]  rx;
  logic        ready;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_nack;
  logic        busy;
  logic        scl_oe;
  logic        sda_oe;
  logic        stall;

  // SDA pull-down for a bit slot: slot 0 is the ack slot, owned by the target on WRITE.
  function automatic logic slot_drive(input logic rd, input logic [3:0] idx,
                                      input logic b, input logic mk);
    if (idx == 4'd0) begin
      slot_drive = rd ? ~mk : 1'b0;
    end else begin
      slot_drive = rd ? 1'b0 : ~b;
    end
  endfunction

  // While SCL is released in q1 but still sensed low, the target is stretching the clock.
  assign stall = (ph == 2'd1) && !bus.scl_i && ((state == S_BIT) || (state == S_STOP));

  assign bus.cmd_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_nack  = rsp_nack;
  assign bus.busy      = busy;
  assign bus.scl_oe    = scl_oe;
  assign bus.sda_oe    = sda_oe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      ph        <= 2'd0;
      bit_idx   <= 4'd0;
      is_read   <= 1'b0;
      mack      <= 1'b0;
      tx        <= 8'h00;
      rx        <= 8'h00;
      ready     <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_nack  <= 1'b0;
      busy      <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          rsp_valid <= 1'b0;
          if (bus.cmd_valid && ready) begin
            ready    <= 1'b0;
            busy     <= 1'b1;
            cnt      <= 16'd0;
            ph       <= 2'd0;
            bit_idx  <= 4'd8;
            rsp_nack <= 1'b0;
            tx       <= bus.cmd_wdata;
            mack     <= bus.cmd_mack;
            is_read  <= (bus.cmd_code == CMD_READ);
            case (bus.cmd_code)
              CMD_START: begin
                state  <= S_START;
                sda_oe <= 1'b0;
              end
              CMD_STOP: begin
                state  <= S_STOP;
                scl_oe <= 1'b1;
                sda_oe <= 1'b1;
              end
              default: begin
                state  <= S_BIT;
                scl_oe <= 1'b1;
                sda_oe <= slot_drive(bus.cmd_code == CMD_READ, 4'd8,
                                     bus.cmd_wdata[7], bus.cmd_mack);
              end
            endcase
          end else begin
            ready <= 1'b1;
          end
        end
        S_START, S_BIT, S_STOP: begin
          if (stall) begin
            cnt <= cnt;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + 16'd1;
          end else begin
            cnt <= 16'd0;
            ph  <= ph + 2'd1;
            if (state == S_START) begin
              case (ph)
                2'd0:    scl_oe <= 1'b0;
                2'd1:    sda_oe <= 1'b1;
                2'd2:    scl_oe <= 1'b1;
                default: state  <= S_RESP;
              endcase
            end else if (state == S_STOP) begin
              case (ph)
                2'd0:    scl_oe <= 1'b0;
                2'd1:    sda_oe <= 1'b0;
                2'd3:    state  <= S_RESP;
                default: sda_oe <= sda_oe;
              endcase
            end else begin
              case (ph)
                2'd0: scl_oe <= 1'b0;
                2'd2: begin
                  scl_oe <= 1'b1;
                  if (bit_idx != 4'd0) begin
                    rx <= {rx[6:0], bus.sda_i};
                  end else if (!is_read) begin
                    rsp_nack <= bus.sda_i;
                  end else begin
                    rsp_nack <= 1'b0;
                  end
                end
                2'd3: begin
                  // Next slot's SDA is set together with the SCL-low quarter that starts it.
                  if (bit_idx == 4'd0) begin
                    state <= S_RESP;
                  end else begin
                    bit_idx <= bit_idx - 4'd1;
                    tx      <= {tx[6:0], 1'b0};
                    sda_oe  <= slot_drive(is_read, bit_idx - 4'd1, tx[6], mack);
                  end
                end
                default: scl_oe <= scl_oe;
              endcase
            end
          end
        end
        S_RESP: begin
          rsp_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
          if (is_read) begin
            rsp_rdata <= rx;
          end else begin
            rsp_rdata <= rsp_rdata;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: command table with a response scoreboard, plus a small
// behavioural EEPROM target at address 0x50 on an open-drain bus model.
module tb_i2c_master_byte;
  localparam int DIV       = 4;
  localparam int LAT_SHORT = 4 * DIV + 1;
  localparam int LAT_BYTE  = 36 * DIV + 1;

  typedef struct {
    logic [1:0] code;
    logic [7:0] wdata;
    logic       mack;
    logic       nack;
    logic       chk_rd;
    logic [7:0] rdata;
    int         lat;
  } vec_t;

  typedef struct {
    string      name;
    logic       nack;
    logic       chk_rd;
    logic [7:0] rdata;
    int         lat;
    int         acc;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic tgt_drv = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  sb_t  sbq[$];
  vec_t vecs[15];

  i2c_master_byte_if bus();
  i2c_master_byte #(.DIVIDER(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.scl_i = ~bus.scl_oe & ~hold;
  assign bus.sda_i = ~bus.sda_oe & ~tgt_drv;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // EEPROM target model: 7-bit address 0x50, word pointer, sequential read/write.
  logic       ps = 1'b1, pd = 1'b1, rd = 1'b0, active = 1'b0, mem_init = 1'b0;
  int         bc = 0, starts = 0, stops = 0;
  logic [7:0] sh = 8'h00, txb = 8'h00, ptr = 8'h00;
  logic [1:0] tph = 2'd0;
  logic [7:0] mem [256];

  always @(posedge clk) begin
    ps <= bus.scl_i;
    pd <= bus.sda_i;
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem_init <= 1'b1;
    end
    if (ps && bus.scl_i && pd && !bus.sda_i) begin
      starts <= starts + 1; active <= 1'b1; tph <= 2'd0; bc <= 0; rd <= 1'b0; tgt_drv <= 1'b0;
    end else if (ps && bus.scl_i && !pd && bus.sda_i) begin
      stops <= stops + 1; active <= 1'b0; tgt_drv <= 1'b0;
    end else if (active && !ps && bus.scl_i) begin
      if (bc < 8) sh <= {sh[6:0], bus.sda_i};
      if (bc == 8 && rd && bus.sda_i) active <= 1'b0;
      bc <= bc + 1;
    end else if (active && ps && !bus.scl_i) begin
      if (bc == 8) begin
        if (rd) tgt_drv <= 1'b0;
        else if (tph == 2'd0) begin
          if (sh[7:1] == 7'h50) tgt_drv <= 1'b1;
          else begin active <= 1'b0; tgt_drv <= 1'b0; end
        end else if (tph == 2'd1) begin
          ptr <= sh; tph <= 2'd2; tgt_drv <= 1'b1;
        end else begin
          mem[ptr] <= sh; ptr <= ptr + 8'd1; tgt_drv <= 1'b1;
        end
      end else if (bc == 9) begin
        bc <= 0;
        tgt_drv <= 1'b0;
        if (tph == 2'd0) tph <= 2'd1;
        if ((tph == 2'd0 && sh[0]) || rd) begin
          rd <= 1'b1; txb <= mem[ptr]; tgt_drv <= ~mem[ptr][7]; ptr <= ptr + 8'd1;
        end
      end else if (rd) begin
        tgt_drv <= ~txb[7 - bc];
      end
    end
  end

  // Clock-stretch injector: holds SCL low during q1 of bit 3 of the armed command.
  logic stretch_on = 1'b0;
  logic sda_ref = 1'b0;
  int   hold_cycles = 0;
  int   sda_changes = 0;
  initial forever begin
    @(posedge clk); #1;
    if (stretch_on && (cyc - acc_cyc) == 84) sda_ref = bus.sda_oe;
    hold = stretch_on && (cyc - acc_cyc) >= 84 && (cyc - acc_cyc) <= 93;
    if (hold) begin
      hold_cycles++;
      if (bus.sda_oe !== sda_ref) sda_changes++;
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid pulse.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        if (sbq.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          e = sbq.pop_front();
          check({e.name, "_nack"}, int'(bus.rsp_nack), int'(e.nack));
          if (e.chk_rd) check({e.name, "_rdata"}, int'(bus.rsp_rdata), int'(e.rdata));
          check({e.name, "_latency"}, cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic do_cmd(input vec_t v, input string nm);
    sb_t e;
    int  t;
    t = 0;
    @(negedge clk);
    while (!bus.cmd_ready && t < 400) begin @(negedge clk); t++; end
    if (!bus.cmd_ready) begin
      fail_now({nm, "_ready_timeout"});
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = v.code;
    bus.cmd_wdata = v.wdata;
    bus.cmd_mack  = v.mack;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    acc_cyc  = cyc;
    e.name   = nm;
    e.nack   = v.nack;
    e.chk_rd = v.chk_rd;
    e.rdata  = v.rdata;
    e.lat    = v.lat;
    e.acc    = cyc;
    sbq.push_back(e);
    t = 0;
    while (sbq.size() != 0 && t < 3000) begin @(posedge clk); t++; end
    check({nm, "_completed"}, sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, p0, bad, seen;
    vec_t v;
    vecs[0]  = '{2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, LAT_SHORT};
    vecs[1]  = '{2'd1, 8'hA0, 1'b0, 1'b0, 1'b0, 8'h00, LAT_BYTE};
    vecs[2]  = '{2'd1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, LAT_BYTE};
    vecs[3]  = '{2'd1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, LAT_BYTE};
    vecs[4]  = '{2'd3, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, LAT_SHORT};
    vecs[5]  = '{2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, LAT_SHORT};
    vecs[6]  = '{2'd1, 8'hA0, 1'b0, 1'b0, 1'b0, 8'h00, LAT_BYTE};
    vecs[7]  = '{2'd1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, LAT_BYTE};
    vecs[8]  = '{2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, LAT_SHORT};
    vecs[9]  = '{2'd1, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00, LAT_BYTE};
    vecs[10] = '{2'd2, 8'h00, 1'b1, 1'b0, 1'b1, 8'h20, LAT_BYTE};
    vecs[11] = '{2'd3, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, LAT_SHORT};
    vecs[12] = '{2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, LAT_SHORT};
    vecs[13] = '{2'd1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h00, LAT_BYTE};
    vecs[14] = '{2'd3, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, LAT_SHORT};

    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 2'd0;
    bus.cmd_wdata = 8'h00;
    bus.cmd_mack  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_rsp_rdata", int'(bus.rsp_rdata), 0);
    check("rst_rsp_nack", int'(bus.rsp_nack), 0);
    check("rst_scl_oe", int'(bus.scl_oe), 0);
    check("rst_sda_oe", int'(bus.sda_oe), 0);

    // Reset in the middle of a WRITE while bit index 5 drives SDA low.
    do_cmd(vecs[0], "pre_start");
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = 2'd1;
    bus.cmd_wdata = 8'h00;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (49) @(posedge clk);
    #1 check("midwrite_sda_low", int'(bus.sda_oe), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_scl_oe", int'(bus.scl_oe), 0);
    check("midrst_sda_oe", int'(bus.sda_oe), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_cmd_ready", int'(bus.cmd_ready), 1);
    do_cmd(vecs[0], "post_rst_start");

    for (int i = 0; i < 5; i++) do_cmd(vecs[i], $sformatf("wr_vec%0d", i));
    check("eeprom_mem_10", int'(mem[8'h10]), 8'h5A);

    s0 = starts;
    for (int i = 5; i < 12; i++) do_cmd(vecs[i], $sformatf("rd_vec%0d", i));
    check("read_start_count", starts - s0, 2);

    p0 = stops;
    for (int i = 12; i < 15; i++) do_cmd(vecs[i], $sformatf("nack_vec%0d", i));
    check("nack_stop_count", stops - p0, 1);

    // SCL stretched by 10 cycles during bit 3 of a WRITE.
    do_cmd(vecs[0], "str_start");
    v = vecs[1];
    v.lat = LAT_BYTE + 10;
    hold_cycles = 0;
    sda_changes = 0;
    stretch_on = 1'b1;
    do_cmd(v, "str_write");
    stretch_on = 1'b0;
    check("stretch_hold_cycles", hold_cycles, 10);
    check("stretch_sda_changes", sda_changes, 0);
    do_cmd(vecs[4], "str_stop");

    // cmd_valid held high with changing codes while busy.
    s0 = starts;
    p0 = stops;
    bad = 0;
    seen = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = 2'd0;
    @(posedge clk); #1;
    acc_cyc = cyc;
    sbq.push_back('{"busy_start", 1'b0, 1'b0, 8'h00, LAT_SHORT, cyc});
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        seen = 1;
        break;
      end
      if (bus.cmd_ready) bad++;
      bus.cmd_code = bus.cmd_code + 2'd1;
    end
    if (seen == 0) fail_now("busy_rsp_timeout");
    check("busy_ready_at_rsp", int'(bus.cmd_ready), 0);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("busy_ready_after_rsp", int'(bus.cmd_ready), 1);
    check("busy_ready_low_count", bad, 0);
    repeat (40) @(posedge clk);
    #1;
    check("busy_idle_after", int'(bus.busy), 0);
    check("busy_start_count", starts - s0, 1);
    check("busy_stop_count", stops - p0, 0);
    do_cmd(vecs[4], "busy_stop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
